mem_access_stage: RTL

- MEM stage that consumes the EX/MEM pipeline register outputs and performs data-memory loads and stores.
- Talks to a valid/ready data-memory port with a separate response channel; tolerates multi-cycle memory.
- Formats load data by width, offset and sign, and holds the pipeline via stall_req while an access is in flight.
- Feeds the MEM/WB register with the writeback value, rename tags and a valid/exception indication.

---
 rtl/mem_access_stage_pkg.sv | 29 ++
 rtl/mem_byte_formatter.sv | 41 ++++
 rtl/mem_access_stage.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_pkg.sv
// ============================================================================
// Module   : mem_access_stage_pkg
// Brief    : Shared encodings and helpers for the MEM access stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic       MEM_WIDTH_WORD = 1'b0;
    localparam logic       MEM_WIDTH_BYTE = 1'b1;
    localparam logic       MEM_READ       = 1'b0;
    localparam logic       MEM_WRITE      = 1'b1;
    localparam logic [3:0] STRB_ALL       = 4'b1111;

    function automatic logic [31:0] byte_extend(input logic [7:0] b, input logic sext);
        return sext ? {{24{b[7]}}, b} : {24'd0, b};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_byte_formatter.sv
// ============================================================================
// Module   : mem_byte_formatter
// Brief    : Store strobe/data replication and load lane select + extension.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_byte_formatter
    import mem_access_stage_pkg::*;
(
    input  logic [1:0]  offset_i,
    input  logic        width_i,
    input  logic        sign_extend_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] load_raw_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [7:0] lane;

    always_comb begin
        lane = load_raw_i[7:0];
        case (offset_i)
            2'd0: lane = load_raw_i[7:0];
            2'd1: lane = load_raw_i[15:8];
            2'd2: lane = load_raw_i[23:16];
            2'd3: lane = load_raw_i[31:24];
            default: lane = load_raw_i[7:0];
        endcase
    end

    // Byte stores replicate the byte on every lane; the strobe picks the real one.
    assign wstrb_o     = (width_i == MEM_WIDTH_BYTE) ? (4'b0001 << offset_i) : STRB_ALL;
    assign wdata_o     = (width_i == MEM_WIDTH_BYTE) ? {4{store_data_i[7:0]}} : store_data_i;
    assign load_data_o = (width_i == MEM_WIDTH_BYTE) ? byte_extend(lane, sign_extend_i) : load_raw_i;

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ============================================================================
// Module   : mem_access_stage
// Brief    : Pipeline MEM stage driving a valid/ready data-memory port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int FREE_LIST_WIDTH = 3
)
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [ADDR_WIDTH-1:0]      pc_in,
    input  logic [DATA_WIDTH-1:0]      inst_in,
    input  logic [DATA_WIDTH-1:0]      alu_res_in,
    input  logic                       mem_enable_in,
    input  logic                       mem_rw_in,
    input  logic                       mem_width_in,
    input  logic                       sign_extend_in,
    input  logic [DATA_WIDTH-1:0]      mem_write_in,
    input  logic                       wb_src_in,
    input  logic                       wb_reg_in,
    input  logic                       branch_in,
    input  logic [REG_ADDR_WIDTH-1:0]  virtual_write_addr_in,
    input  logic [REG_ADDR_WIDTH:0]    physical_write_addr_in,
    input  logic [FREE_LIST_WIDTH-1:0] active_list_index_in,
    output logic                       dmem_req_valid,
    input  logic                       dmem_req_ready,
    output logic                       dmem_req_we,
    output logic [ADDR_WIDTH-1:0]      dmem_addr,
    output logic [DATA_WIDTH-1:0]      dmem_wdata,
    output logic [3:0]                 dmem_wstrb,
    input  logic                       dmem_rvalid,
    input  logic [DATA_WIDTH-1:0]      dmem_rdata,
    output logic                       stall_req,
    output logic                       wb_valid,
    output logic [DATA_WIDTH-1:0]      wb_data,
    output logic                       align_exc,
    output logic [ADDR_WIDTH-1:0]      pc_out,
    output logic [DATA_WIDTH-1:0]      inst_out,
    output logic                       wb_reg_out,
    output logic                       branch_out,
    output logic [REG_ADDR_WIDTH-1:0]  virtual_write_addr_out,
    output logic [REG_ADDR_WIDTH:0]    physical_write_addr_out,
    output logic [FREE_LIST_WIDTH-1:0] active_list_index_out
);

    state_e                state_q;
    logic                  kill_q;
    logic [DATA_WIDTH-1:0] load_q;

    logic                  misaligned;
    logic                  is_load;
    logic                  issue;
    logic [31:0]           load_fmt;

    mem_byte_formatter u_fmt (
        .offset_i      (alu_res_in[1:0]),
        .width_i       (mem_width_in),
        .sign_extend_i (sign_extend_in),
        .store_data_i  (mem_write_in),
        .load_raw_i    (dmem_rdata),
        .wstrb_o       (dmem_wstrb),
        .wdata_o       (dmem_wdata),
        .load_data_o   (load_fmt)
    );

    assign misaligned = mem_enable_in && (mem_width_in == MEM_WIDTH_WORD) &&
                        (alu_res_in[1:0] != 2'b00);
    assign is_load    = (mem_rw_in == MEM_READ);
    assign issue      = (state_q == ST_IDLE) && mem_enable_in && !misaligned && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            kill_q  <= 1'b0;
            load_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        if (dmem_req_ready) begin
                            state_q <= is_load ? ST_RESP : ST_DONE;
                        end else begin
                            state_q <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                    end else if (dmem_req_ready) begin
                        state_q <= is_load ? ST_RESP : ST_DONE;
                    end
                end
                ST_RESP: begin
                    // A flushed load still drains its response before retiring.
                    if (flush) begin
                        kill_q <= 1'b1;
                    end
                    if (dmem_rvalid) begin
                        load_q  <= load_fmt;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    kill_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Handshake and writeback outputs are forced quiet while reset is held.
    always_comb begin
        dmem_req_valid = 1'b0;
        stall_req      = 1'b0;
        wb_valid       = 1'b0;
        align_exc      = 1'b0;
        wb_data        = alu_res_in;
        if (rst_n) begin
            case (state_q)
                ST_IDLE: begin
                    dmem_req_valid = issue;
                    stall_req      = issue;
                    align_exc      = misaligned && !flush;
                    wb_valid       = !flush && (!mem_enable_in || misaligned);
                end
                ST_REQ: begin
                    dmem_req_valid = !flush;
                    stall_req      = !flush;
                end
                ST_RESP: begin
                    stall_req = 1'b1;
                end
                ST_DONE: begin
                    wb_valid = !kill_q && !flush;
                    if (mem_enable_in && is_load && wb_src_in) begin
                        wb_data = load_q;
                    end
                end
                default: begin
                    stall_req = 1'b0;
                end
            endcase
        end
    end

    assign dmem_req_we             = mem_rw_in;
    assign dmem_addr               = {alu_res_in[ADDR_WIDTH-1:2], 2'b00};
    assign pc_out                  = pc_in;
    assign inst_out                = inst_in;
    assign wb_reg_out              = wb_reg_in && !align_exc;
    assign branch_out              = branch_in;
    assign virtual_write_addr_out  = virtual_write_addr_in;
    assign physical_write_addr_out = physical_write_addr_in;
    assign active_list_index_out   = active_list_index_in;

endmodule

`default_nettype wire
